// File: rtl/operand_sequencer.sv
// Debounces one active-low push button and steps a three-state FSM that latches
// two operands from a single switch bank, one per press; a third press clears them.
module operand_sequencer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [1:0]       o_state,
    output logic             o_sum_valid
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        RESULT  = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;

    // Two-flop synchronizer, then a level debouncer that emits one pulse per accepted press.
    always_comb begin
        sync1_d = i_key;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // State register together with the registered operand outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (press_q) state_d = LOAD_B;
            LOAD_B:  if (press_q) state_d = RESULT;
            RESULT:  if (press_q) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    // Operands are sampled from the switches only in the press-pulse cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        valid_d = (state_d == RESULT);
        case (state_q)
            LOAD_A: if (press_q) a_d = i_operand;
            LOAD_B: if (press_q) b_d = i_operand;
            RESULT: begin
                if (press_q) begin
                    a_d = '0;
                    b_d = '0;
                end
            end
            default: begin
                a_d = '0;
                b_d = '0;
            end
        endcase
    end

    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_state     = state_q;
    assign o_sum_valid = valid_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed vector table, hand-written
// latency/reset sequences, and randomized key activity against a behavioural model.
module tb_operand_sequencer;

    localparam int unsigned W   = 4;
    localparam int unsigned DEB = 4;

    logic         clk;
    logic         rst_n;
    logic         key;
    logic [W-1:0] operand;
    logic [W-1:0] o_a, o_b;
    logic [1:0]   o_state;
    logic         o_sum_valid;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_operand(operand),
        .o_a(o_a), .o_b(o_b), .o_state(o_state), .o_sum_valid(o_sum_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: raw key samples, delayed by two edges, must disagree with the
    // accepted level for DEB consecutive edges to flip it; a falling flip is a press
    // acted on at the following edge, cycling operand phase 0 -> 1 -> 2 -> 0.
    logic         raw_q[$];
    logic         ks_h[$];
    logic         m_deb;
    logic         m_fell;
    int           m_phase;
    logic [W-1:0] m_a, m_b;

    task automatic model_reset();
        raw_q.delete();
        ks_h.delete();
        m_deb   = 1'b1;
        m_fell  = 1'b0;
        m_phase = 0;
        m_a     = '0;
        m_b     = '0;
    endtask

    task automatic model_edge();
        logic ks;
        bit   flip;
        bit   press;
        press = m_fell;
        raw_q.push_back(key);
        ks = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : 1'b1;
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        ks_h.push_back(ks);
        if (ks_h.size() > DEB) void'(ks_h.pop_front());
        flip = (ks_h.size() == DEB);
        foreach (ks_h[j]) if (ks_h[j] == m_deb) flip = 1'b0;
        m_fell = flip && m_deb;
        if (flip) m_deb = ~m_deb;
        if (press) begin
            case (m_phase)
                0: begin m_a = operand; m_phase = 1; end
                1: begin m_b = operand; m_phase = 2; end
                default: begin m_a = '0; m_b = '0; m_phase = 0; end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input logic [1:0] es, input logic ev);
        check({name, ".a"}, 32'(o_a), 32'(ea));
        check({name, ".b"}, 32'(o_b), 32'(eb));
        check({name, ".state"}, 32'(o_state), 32'(es));
        check({name, ".valid"}, 32'(o_sum_valid), 32'(ev));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        cycle++;
        #1;
        check_outs("model", m_a, m_b, 2'(m_phase), m_phase == 2);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("async_rst", '0, '0, 2'b00, 1'b0);
    endtask

    task automatic press(input logic [W-1:0] op);
        operand = op;
        key = 1'b0;
        repeat (10) tick();
        key = 1'b1;
        repeat (10) tick();
    endtask

    typedef struct {
        logic         key;
        logic [W-1:0] op;
        int           cyc;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [1:0]   es;
        logic         ev;
        string        name;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [W-1:0] held_op;
        int           run;

        tbl[0]  = '{1'b0, 4'h9, 8,  4'h9, 4'h0, 2'b01, 1'b0, "press_a"};
        tbl[1]  = '{1'b1, 4'h9, 8,  4'h9, 4'h0, 2'b01, 1'b0, "release_a"};
        tbl[2]  = '{1'b0, 4'h7, 8,  4'h9, 4'h7, 2'b10, 1'b1, "press_b"};
        tbl[3]  = '{1'b1, 4'h7, 8,  4'h9, 4'h7, 2'b10, 1'b1, "release_b"};
        tbl[4]  = '{1'b0, 4'hF, 8,  4'h0, 4'h0, 2'b00, 1'b0, "press_clear"};
        tbl[5]  = '{1'b1, 4'hF, 8,  4'h0, 4'h0, 2'b00, 1'b0, "release_clear"};
        tbl[6]  = '{1'b0, 4'h5, 3,  4'h0, 4'h0, 2'b00, 1'b0, "bounce_lo1"};
        tbl[7]  = '{1'b1, 4'h5, 1,  4'h0, 4'h0, 2'b00, 1'b0, "bounce_hi"};
        tbl[8]  = '{1'b0, 4'h5, 3,  4'h0, 4'h0, 2'b00, 1'b0, "bounce_lo2"};
        tbl[9]  = '{1'b1, 4'h5, 8,  4'h0, 4'h0, 2'b00, 1'b0, "bounce_end"};
        tbl[10] = '{1'b0, 4'h5, 10, 4'h5, 4'h0, 2'b01, 1'b0, "long_press"};
        tbl[11] = '{1'b1, 4'h3, 8,  4'h5, 4'h0, 2'b01, 1'b0, "op3_no_press"};
        tbl[12] = '{1'b1, 4'hC, 4,  4'h5, 4'h0, 2'b01, 1'b0, "opC_no_press"};

        // Reset held with key pressed and switches at F.
        rst_n   = 1'b0;
        key     = 1'b0;
        operand = 4'hF;
        model_reset();
        repeat (3) tick();
        check_outs("reset", '0, '0, 2'b00, 1'b0);
        key   = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        foreach (tbl[i]) begin
            key     = tbl[i].key;
            operand = tbl[i].op;
            repeat (tbl[i].cyc) tick();
            check_outs(tbl[i].name, tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ev);
        end

        // Held key with switches changing every cycle: one load at the sixth edge.
        assert_reset();
        key = 1'b1;
        repeat (2) tick();
        rst_n   = 1'b1;
        repeat (4) tick();
        held_op = '0;
        for (int i = 0; i < 100; i++) begin
            key     = 1'b0;
            operand = W'($urandom);
            if (i == 6) held_op = operand;
            tick();
            if (i == 5) check_outs("hold_pre", '0, '0, 2'b00, 1'b0);
            if (i == 6) check_outs("hold_load", held_op, '0, 2'b01, 1'b0);
        end
        check_outs("hold_end", held_op, '0, 2'b01, 1'b0);
        key = 1'b1;
        repeat (10) tick();
        check_outs("hold_release", held_op, '0, 2'b01, 1'b0);

        // Reach RESULT, then reset partway through debouncing the next press.
        press(4'hA);
        check_outs("in_result", held_op, 4'hA, 2'b10, 1'b1);
        key = 1'b0;
        repeat (4) tick();
        assert_reset();
        key = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        press(4'h6);
        check_outs("post_rst_press", 4'h6, '0, 2'b01, 1'b0);

        // Key held through reset release produces exactly one press.
        assert_reset();
        key     = 1'b0;
        operand = 4'hB;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_outs("held_thru_rst", 4'hB, '0, 2'b01, 1'b0);
        key = 1'b1;
        repeat (10) tick();

        // Randomized bouncy key and switch activity with rare resets.
        for (int n = 0; n < 600; n++) begin
            key = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 9);
            for (int k = 0; k < run; k++) begin
                operand = W'($urandom);
                tick();
            end
            if ($urandom_range(0, 99) == 0) begin
                assert_reset();
                tick();
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
